// File: rtl/mem_fill_controller.sv
// Cache miss-service and write-through controller: fetches a missing 16-byte block as
// pipelined word reads into the icache or dcache, and forwards stores to main memory.
module mem_fill_controller #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss,
    input  logic [15:0] icache_miss_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_miss_addr,
    input  logic        store_req,
    input  logic [15:0] store_addr,
    input  logic [15:0] store_data,
    output logic        store_ack,
    output logic        stall_n,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        icache_wr_data,
    output logic        icache_wr_tag,
    output logic        dcache_wr_data,
    output logic        dcache_wr_tag,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [3:0] ISSUE_END = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0] RET_LAST  = 3'(WORDS_PER_BLOCK - 1);

    state_t      state;
    logic [15:0] base;
    logic        target;
    logic [3:0]  issue_cnt;
    logic [2:0]  ret_cnt;

    logic        issuing;
    logic        ret_accept;
    logic        ret_last;

    assign issuing  = (state == FILL) && (issue_cnt < ISSUE_END);
    assign ret_last = (ret_cnt == RET_LAST);

    // A return is only genuine once its request is at least MEM_LATENCY issues old.
    assign ret_accept = (state == FILL) && mem_data_valid &&
                        ((issue_cnt == ISSUE_END) ||
                         (int'(ret_cnt) + MEM_LATENCY <= int'(issue_cnt)));

    assign stall_n = ~((state == FILL) | icache_miss | dcache_miss);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= 16'h0000;
            target    <= 1'b0;
            issue_cnt <= 4'd0;
            ret_cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (dcache_miss) begin
                        base   <= dcache_miss_addr & 16'hFFF0;
                        target <= 1'b1;
                        state  <= FILL;
                    end else if (icache_miss) begin
                        base   <= icache_miss_addr & 16'hFFF0;
                        target <= 1'b0;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 4'd1;
                    end
                    if (ret_accept) begin
                        if (ret_last) begin
                            issue_cnt <= 4'd0;
                            ret_cnt   <= 3'd0;
                            state     <= IDLE;
                        end else begin
                            ret_cnt <= ret_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        store_ack      = 1'b0;
        fill_addr      = 16'h0000;
        fill_data      = 16'h0000;
        icache_wr_data = 1'b0;
        icache_wr_tag  = 1'b0;
        dcache_wr_data = 1'b0;
        dcache_wr_tag  = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_in    = 16'h0000;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        if (state == IDLE) begin
            // Stores yield to any miss; the store is retried once the fill is done.
            if (!dcache_miss && !icache_miss && store_req) begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = store_addr;
                mem_data_in = store_data;
                store_ack   = 1'b1;
            end
        end else begin
            if (issuing) begin
                mem_enable = 1'b1;
                mem_addr   = base + {11'b0, issue_cnt, 1'b0};
            end
            if (ret_accept) begin
                fill_data = mem_data_out;
                fill_addr = base + {12'b0, ret_cnt, 1'b0};
                if (target) begin
                    dcache_wr_data = 1'b1;
                    dcache_wr_tag  = ret_last;
                end else begin
                    icache_wr_data = 1'b1;
                    icache_wr_tag  = ret_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_controller.sv
// Bench for mem_fill_controller: a 4-cycle pipelined memory stub, a cycle-schedule model of
// the fill/store behaviour compared every cycle, and directed scenarios with literal checks.
module tb_mem_fill_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        store_req;
    logic [15:0] store_addr;
    logic [15:0] store_data;
    logic        store_ack;
    logic        stall_n;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        icache_wr_data;
    logic        icache_wr_tag;
    logic        dcache_wr_data;
    logic        dcache_wr_tag;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;

    int error_count = 0;
    int check_count = 0;
    bit checking = 1'b0;

    mem_fill_controller #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
        .store_ack(store_ack), .stall_n(stall_n),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .icache_wr_data(icache_wr_data), .icache_wr_tag(icache_wr_tag),
        .dcache_wr_data(dcache_wr_data), .dcache_wr_tag(dcache_wr_tag),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    // Memory stub: word k of any block reads as A000+k, four cycles after the request.
    logic [3:0]  pipe_v = 4'b0000;
    logic [15:0] pipe_a [4];
    always @(posedge clk) begin
        if (rst) begin
            pipe_v <= 4'b0000;
        end else begin
            pipe_v    <= {pipe_v[2:0], mem_enable && !mem_wr};
            pipe_a[0] <= mem_addr;
            for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign mem_data_valid = pipe_v[3];
    assign mem_data_out   = pipe_v[3] ? (16'hA000 + {13'b0, pipe_a[3][3:1]}) : 16'h0000;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic im, input logic [15:0] ia, input logic dm,
                                 input logic [15:0] da, input logic sr, input logic [15:0] sa,
                                 input logic [15:0] sd);
        icache_miss      = im;
        icache_miss_addr = ia;
        dcache_miss      = dm;
        dcache_miss_addr = da;
        store_req        = sr;
        store_addr       = sa;
        store_data       = sd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Schedule model: a miss seen in idle cycle t0 issues at t0+1..t0+8, returns at t0+5..t0+12.
    int          cyc = 0;
    int          t0 = 0;
    bit          in_fill = 1'b0;
    logic [15:0] m_base = 16'h0000;
    bit          m_dcache = 1'b0;

    always @(negedge clk) begin
        int          d;
        logic        e_ack, e_stall_n, e_iwd, e_iwt, e_dwd, e_dwt, e_en, e_wr;
        logic [15:0] e_fa, e_fd, e_ma, e_md;
        if (checking) begin
            d = cyc - t0;
            {e_ack, e_iwd, e_iwt, e_dwd, e_dwt, e_en, e_wr} = '0;
            {e_fa, e_fd, e_ma, e_md} = '0;
            e_stall_n = !(in_fill || icache_miss || dcache_miss);
            if (in_fill) begin
                if (d >= 1 && d <= 8) begin
                    e_en = 1'b1;
                    e_ma = m_base + 16'(2 * (d - 1));
                end
                if (d >= 5 && d <= 12) begin
                    e_fa = m_base + 16'(2 * (d - 5));
                    e_fd = 16'hA000 + 16'(d - 5);
                    if (m_dcache) begin
                        e_dwd = 1'b1;
                        e_dwt = (d == 12);
                    end else begin
                        e_iwd = 1'b1;
                        e_iwt = (d == 12);
                    end
                end
            end else if (!dcache_miss && !icache_miss && store_req) begin
                e_en  = 1'b1;
                e_wr  = 1'b1;
                e_ma  = store_addr;
                e_md  = store_data;
                e_ack = 1'b1;
            end
            checkOutput("store_ack", 16'(store_ack), 16'(e_ack));
            checkOutput("stall_n", 16'(stall_n), 16'(e_stall_n));
            checkOutput("fill_addr", fill_addr, e_fa);
            checkOutput("fill_data", fill_data, e_fd);
            checkOutput("icache_wr_data", 16'(icache_wr_data), 16'(e_iwd));
            checkOutput("icache_wr_tag", 16'(icache_wr_tag), 16'(e_iwt));
            checkOutput("dcache_wr_data", 16'(dcache_wr_data), 16'(e_dwd));
            checkOutput("dcache_wr_tag", 16'(dcache_wr_tag), 16'(e_dwt));
            checkOutput("mem_enable", 16'(mem_enable), 16'(e_en));
            checkOutput("mem_wr", 16'(mem_wr), 16'(e_wr));
            checkOutput("mem_addr", mem_addr, e_ma);
            checkOutput("mem_data_in", mem_data_in, e_md);

            if (rst) begin
                in_fill = 1'b0;
            end else if (in_fill) begin
                if (d == 12) in_fill = 1'b0;
            end else if (dcache_miss) begin
                in_fill  = 1'b1;
                t0       = cyc;
                m_base   = dcache_miss_addr & 16'hFFF0;
                m_dcache = 1'b1;
            end else if (icache_miss) begin
                in_fill  = 1'b1;
                t0       = cyc;
                m_base   = icache_miss_addr & 16'hFFF0;
                m_dcache = 1'b0;
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        next_cycle();
        checking = 1'b1;
        #3;
        checkOutput("reset mem_enable", 16'(mem_enable), 16'h0);
        checkOutput("reset store_ack", 16'(store_ack), 16'h0);
        checkOutput("reset stall_n", 16'(stall_n), 16'h1);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        $display("[TB] icache miss at 0x0046");
        applyStimulus(1, 16'h0046, 0, 16'h0, 0, 16'h0, 16'h0);
        for (int d = 0; d <= 12; d++) begin
            #3;
            case (d)
                0: checkOutput("imiss stall T", 16'(stall_n), 16'h0);
                1: begin
                    checkOutput("imiss first req addr", mem_addr, 16'h0040);
                    checkOutput("imiss first req en", 16'(mem_enable), 16'h1);
                end
                5: begin
                    checkOutput("imiss first wr_data", 16'(icache_wr_data), 16'h1);
                    checkOutput("imiss first fill_addr", fill_addr, 16'h0040);
                    checkOutput("imiss first fill_data", fill_data, 16'hA000);
                end
                8: checkOutput("imiss last req addr", mem_addr, 16'h004E);
                11: checkOutput("imiss early tag", 16'(icache_wr_tag), 16'h0);
                12: begin
                    checkOutput("imiss tag", 16'(icache_wr_tag), 16'h1);
                    checkOutput("imiss last fill_addr", fill_addr, 16'h004E);
                    checkOutput("imiss last fill_data", fill_data, 16'hA007);
                    checkOutput("imiss stall T+12", 16'(stall_n), 16'h0);
                end
                default: ;
            endcase
            next_cycle();
        end
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        #3;
        checkOutput("imiss stall released", 16'(stall_n), 16'h1);
        next_cycle();

        $display("[TB] simultaneous icache 0x0010 and dcache 0x2002");
        applyStimulus(1, 16'h0010, 1, 16'h2002, 0, 16'h0, 16'h0);
        for (int d = 0; d <= 25; d++) begin
            if (d == 13) dcache_miss = 1'b0;
            #3;
            case (d)
                1: checkOutput("dual dcache req", mem_addr, 16'h2000);
                12: begin
                    checkOutput("dual dcache tag", 16'(dcache_wr_tag), 16'h1);
                    checkOutput("dual no icache tag", 16'(icache_wr_tag), 16'h0);
                end
                13: begin
                    checkOutput("dual idle stall", 16'(stall_n), 16'h0);
                    checkOutput("dual idle no req", 16'(mem_enable), 16'h0);
                end
                14: checkOutput("dual icache req", mem_addr, 16'h0010);
                25: checkOutput("dual icache tag", 16'(icache_wr_tag), 16'h1);
                default: ;
            endcase
            next_cycle();
        end
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        next_cycle();

        $display("[TB] back-to-back stores");
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h3004, 16'hBEEF);
        #3;
        checkOutput("store ack", 16'(store_ack), 16'h1);
        checkOutput("store wr", 16'(mem_wr), 16'h1);
        checkOutput("store addr", mem_addr, 16'h3004);
        checkOutput("store data", mem_data_in, 16'hBEEF);
        checkOutput("store stall_n", 16'(stall_n), 16'h1);
        next_cycle();
        applyStimulus(0, 16'h0, 0, 16'h0, 1, 16'h3006, 16'h1234);
        #3;
        checkOutput("store2 ack", 16'(store_ack), 16'h1);
        checkOutput("store2 addr", mem_addr, 16'h3006);
        next_cycle();
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        #3;
        checkOutput("store idle ack", 16'(store_ack), 16'h0);
        next_cycle();

        $display("[TB] store blocked by dcache miss at 0x3004");
        applyStimulus(0, 16'h0, 1, 16'h3004, 1, 16'h3004, 16'h5A5A);
        for (int d = 0; d <= 12; d++) begin
            #3;
            if (d == 0 || d == 6 || d == 12)
                checkOutput("blocked store ack", 16'(store_ack), 16'h0);
            if (d == 12)
                checkOutput("blocked dcache tag", 16'(dcache_wr_tag), 16'h1);
            next_cycle();
        end
        dcache_miss = 1'b0;
        #3;
        checkOutput("late store ack", 16'(store_ack), 16'h1);
        checkOutput("late store data", mem_data_in, 16'h5A5A);
        next_cycle();
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        next_cycle();

        $display("[TB] reset in the middle of a fill");
        applyStimulus(0, 16'h0, 1, 16'h1234, 0, 16'h0, 16'h0);
        for (int d = 0; d < 7; d++) next_cycle();
        rst = 1'b1;
        dcache_miss = 1'b0;
        next_cycle();
        rst = 1'b0;
        #3;
        checkOutput("post-reset mem_enable", 16'(mem_enable), 16'h0);
        checkOutput("post-reset wr_data", 16'(dcache_wr_data), 16'h0);
        checkOutput("post-reset stall_n", 16'(stall_n), 16'h1);
        for (int d = 0; d < 10; d++) begin
            next_cycle();
            #3;
            checkOutput("aborted fill tag", 16'(dcache_wr_tag), 16'h0);
        end
        next_cycle();
        applyStimulus(1, 16'h0100, 0, 16'h0, 0, 16'h0, 16'h0);
        for (int d = 0; d <= 12; d++) begin
            #3;
            if (d == 12) checkOutput("refill tag", 16'(icache_wr_tag), 16'h1);
            next_cycle();
        end
        icache_miss = 1'b0;
        #3;
        checkOutput("refill stall released", 16'(stall_n), 16'h1);
        next_cycle();

        $display("[TB] dcache miss at top of address space");
        applyStimulus(0, 16'h0, 1, 16'hFFFE, 0, 16'h0, 16'h0);
        for (int d = 0; d <= 12; d++) begin
            #3;
            case (d)
                1: checkOutput("wrap first req", mem_addr, 16'hFFF0);
                8: checkOutput("wrap last req", mem_addr, 16'hFFFE);
                12: begin
                    checkOutput("wrap last fill_addr", fill_addr, 16'hFFFE);
                    checkOutput("wrap tag", 16'(dcache_wr_tag), 16'h1);
                end
                default: ;
            endcase
            next_cycle();
        end
        applyStimulus(0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0);
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
